// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: one command in, one AXI transaction, one response out.
// Every AXI wait state is bounded by TIMEOUT cycles and then aborts with a SLVERR-style response.
module axi_lite_master #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,

    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        aw_done;
    logic        w_done;

    logic        waiting;
    logic        expired;
    logic        hs_any;
    logic        abort;

    assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);
    assign expired = (cnt >= 16'(TIMEOUT - 1));
    assign hs_any  = (awvalid && awready) || (wvalid && wready) ||
                     (arvalid && arready) || (bvalid && bready) ||
                     (rvalid && rready);
    // A handshake landing on the expiry cycle wins, as does a write whose AW/W are both already done.
    assign abort   = waiting && expired && !hs_any &&
                     !((state == WR_REQ) && aw_done && w_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else if (abort) begin
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= 32'hDEAD_BEEF;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    cnt <= cnt + 16'd1;
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        cnt    <= '0;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    cnt <= cnt + 16'd1;
                    if (bvalid && bready) begin
                        bready      <= 1'b0;
                        rsp_resp    <= bresp;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RD_REQ: begin
                    cnt <= cnt + 16'd1;
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    cnt <= cnt + 16'd1;
                    if (rvalid && rready) begin
                        rready      <= 1'b0;
                        rsp_rdata   <= rdata;
                        rsp_resp    <= rresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench: 4-register AXI-Lite slave with configurable AW delay, AR stall and B hold.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_master #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Slave model
    int          aw_delay;
    logic        ar_en, b_hold;
    int          aw_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic [31:0] regs [4];

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = 1'b1;
    assign arready = arvalid && ar_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_a    <= '0;
            w_d     <= '0;
            w_s     <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
            if (wvalid && wready)   begin w_got  <= 1'b1; w_d  <= wdata; w_s <= wstrb; end
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_got && w_got && !bvalid && !b_hold) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bvalid <= 1'b1;
                if (aw_a < 32'd16) begin
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) regs[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
                    bresp <= 2'b00;
                end else begin
                    bresp <= 2'b11;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= (araddr < 32'd16) ? regs[araddr[3:2]] : 32'hDEAD_BEEF;
                rresp  <= (araddr < 32'd16) ? 2'b00 : 2'b11;
            end
        end
    end

    // Protocol monitor: cumulative per-cycle counters
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, viol_cnt = 0, rv_cnt = 0;
    always @(negedge clk) begin
        if (awvalid)   aw_cnt++;
        if (wvalid)    w_cnt++;
        if (arvalid)   ar_cnt++;
        if (rsp_valid) rv_cnt++;
        if ((bready && (awvalid || wvalid)) || (rready && arvalid)) viol_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        @(negedge clk);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold,
                       output logic [31:0] rd, output logic [1:0] rs, output logic to,
                       output int lat);
        send_cmd(wr, a, d, s);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata},
                  {1'b1, 1'b0, to, rs, rd});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          lat, aw0, w0, ar0, rv0, n;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready,
                              rsp_timeout, rsp_resp, wstrb}, 64'd0);
        check({tag, "_aw_w"}, {awaddr, wdata}, 64'd0);
        check({tag, "_ar_rsp"}, {araddr, rsp_rdata}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0; aw_delay = 0; ar_en = 1'b1; b_hold = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1 check("cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Basic writes and reads to the register slave
        txn(1'b1, 32'h0, 32'hA5A5_0000, 4'hF, 0, rd, rs, to, lat);
        check("wr0_lat", lat, 4);
        check("wr0_resp", {to, rs, rd}, {1'b0, 2'b00, 32'h0});
        txn(1'b1, 32'h4, 32'hDEAD_1234, 4'hF, 0, rd, rs, to, lat);
        check("wr4_resp", {to, rs, rd}, {1'b0, 2'b00, 32'h0});
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("rd0_lat", lat, 3);
        check("rd0_data", {to, rs, rd}, {1'b0, 2'b00, 32'hA5A5_0000});
        txn(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("rd4_data", {to, rs, rd}, {1'b0, 2'b00, 32'hDEAD_1234});

        // Unmapped read returns slave's decode error
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("rd20_data", {to, rs, rd}, {1'b0, 2'b11, 32'hDEAD_BEEF});

        // AW delayed 3 cycles, W immediate
        aw_delay = 3; aw0 = aw_cnt; w0 = w_cnt;
        txn(1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, rd, rs, to, lat);
        aw_delay = 0;
        check("awdly_aw_cycles", aw_cnt - aw0, 4);
        check("awdly_w_cycles", w_cnt - w0, 1);
        check("awdly_lat", lat, 7);
        check("awdly_resp", {to, rs}, {1'b0, 2'b00});
        txn(1'b1, 32'h8, 32'hAAAA_AAAA, 4'b0101, 0, rd, rs, to, lat);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("rd8_strobed", rd, 32'h12AA_56AA);

        // AR never accepted: abort after 8 cycles
        ar_en = 1'b0; ar0 = ar_cnt;
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, rs, to, lat);
        ar_en = 1'b1;
        check("tmo_ar_cycles", ar_cnt - ar0, 8);
        check("tmo_lat", lat, 9);
        check("tmo_resp", {to, rs, rd}, {1'b1, 2'b10, 32'hDEAD_BEEF});

        // Stalled response consumer, and timeout flag cleared by a normal completion
        txn(1'b0, 32'h4, 32'h0, 4'h0, 5, rd, rs, to, lat);
        check("hold_rd4", {to, rs, rd}, {1'b0, 2'b00, 32'hDEAD_1234});

        // Reset while waiting in WR_RESP
        b_hold = 1'b1;
        send_cmd(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF);
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check("reach_wr_resp", bready, 1);
        rv0 = rv_cnt;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0; b_hold = 1'b0;
        #1 check("midrst_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_no_rsp", rv_cnt - rv0, 0);
        txn(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, 0, rd, rs, to, lat);
        check("post_rst_wr", {lat[7:0], to, rs}, {8'd4, 1'b0, 2'b00});
        txn(1'b0, 32'hC, 32'h0, 4'h0, 0, rd, rs, to, lat);
        check("post_rst_rd", {to, rs, rd}, {1'b0, 2'b00, 32'hCAFE_F00D});

        check("ready_order_violations", viol_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
